pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It merges stall requests from ID, EX and MEM into the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It turns MEM-stage exceptions into a one-cycle flush with a target PC, and enforces a one-cycle post-flush lockout. It also keeps stall and flush statistics and, optionally, a stall watchdog.

---
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, turns MEM exceptions into a flush + lockout.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl #(
  parameter int          STALL_LIMIT = 256,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR  = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        wdt_fired
);

  // state | meaning
  // RUN   | pipeline flowing, no stall last cycle
  // STALL | at least one stall request honoured last cycle
  // LOCK  | cycle right after a flush; requests and exceptions ignored
  typedef enum logic [1:0] {RUN, STALL, LOCK} state_t;

  state_t state_q, state_d;
  logic   exc;
  logic   wdt_force;

  if (STALL_LIMIT < 2 || STALL_LIMIT > 65535) begin : g_bad_limit
    $error("pipe_ctrl: STALL_LIMIT out of range 2..65535");
  end

  assign exc = (excepttype != 32'h0);

`ifdef PIPE_CTRL_STALL_WDT_EN
  logic [15:0] run_q;
  logic        wdt_q;

  // run_q only reaches STALL_LIMIT via a stalled cycle at STALL_LIMIT-1, so this is the cycle after.
  assign wdt_force = (state_q == STALL) && (run_q == 16'(STALL_LIMIT));
  assign wdt_fired = wdt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      wdt_q <= 1'b0;
    end else begin
      run_q <= (flush || stall == 6'b0) ? 16'h0 : run_q + 16'h1;
      if (wdt_force) wdt_q <= 1'b1;
    end
  end
`else
  assign wdt_force = 1'b0;
  assign wdt_fired = 1'b0;
`endif

  always_comb begin
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    state_d = state_q;
    if (!rst) begin
      case (state_q)
        LOCK: state_d = RUN;
        default: begin
          if (wdt_force) begin
            flush   = 1'b1;
            new_pc  = EXC_VECTOR;
            state_d = LOCK;
          end else if (exc) begin
            flush   = 1'b1;
            state_d = LOCK;
            case (excepttype)
              32'h1:   new_pc = INT_VECTOR;
              32'he:   new_pc = cp0_epc;
              default: new_pc = EXC_VECTOR;
            endcase
          end else begin
            if (stallreq_mem)     stall = 6'b011111;
            else if (stallreq_ex) stall = 6'b001111;
            else if (stallreq_id) stall = 6'b000111;
            state_d = (stall != 6'b0) ? STALL : RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q <= state_d;
      if (stall != 6'b0 && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'h1;
      if (flush)
        flush_count <= flush_count + 16'h1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed literal checks plus a per-cycle reference model compare.
module tb_pipe_ctrl;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b1;
  logic [31:0] excepttype = 32'h0, cp0_epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic        wdt_fired;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .wdt_fired(wdt_fired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_locked = 0, m_pend = 0, m_wdt = 0;
  int          m_run = 0;
  longint      m_sc = 0;
  int          m_fc = 0;

  function automatic logic [31:0] target_pc(input logic [31:0] code, input logic [31:0] epc);
    if (code == 32'h1) return 32'h20;
    if (code == 32'he) return epc;
    return 32'h40;
  endfunction

  always @(negedge clk) begin
    int          lvl;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    bit          forced;
    e_stall = 0; e_flush = 0; e_pc = 0; forced = 0;
    if (!rst && !m_locked) begin
`ifdef PIPE_CTRL_STALL_WDT_EN
      forced = m_pend;
`endif
      if (forced) begin
        e_flush = 1; e_pc = 32'h40;
      end else if (excepttype != 0) begin
        e_flush = 1; e_pc = target_pc(excepttype, cp0_epc);
      end else begin
        lvl = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : 0;
        e_stall = 6'((1 << lvl) - 1);
      end
    end
    chk("m_stall", 32'(stall), 32'(e_stall));
    chk("m_flush", 32'(flush), 32'(e_flush));
    chk("m_new_pc", new_pc, e_pc);
    chk("m_stall_cycles", stall_cycles, 32'(m_sc));
    chk("m_flush_count", 32'(flush_count), 32'(m_fc % 65536));
    chk("m_wdt_fired", 32'(wdt_fired), 32'(m_wdt));
    if (rst) begin
      m_locked = 0; m_pend = 0; m_wdt = 0; m_run = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e_stall != 0 && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (e_flush) m_fc++;
      if (forced) m_wdt = 1;
`ifdef PIPE_CTRL_STALL_WDT_EN
      m_pend = (e_stall != 0) && (m_run == LIMIT - 1);
`endif
      m_run = (e_flush || e_stall == 0) ? 0 : m_run + 1;
      m_locked = e_flush;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic r, input logic id, input logic ex, input logic mem,
                     input logic [31:0] code, input logic [31:0] epc);
    @(posedge clk); #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excepttype = code; cp0_epc = epc;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] codes [3];
    logic [31:0] pcs [3];
    logic [31:0] rcodes [8];
    codes = '{32'h1, 32'hc, 32'he};
    pcs   = '{32'h20, 32'h40, 32'h1234};
    rcodes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3, 32'h20};

    // reset with MEM stall pending
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 1, 0, 0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_new_pc", new_pc, 32'h0);
      chk("rst_stall_cycles", stall_cycles, 32'h0);
      chk("rst_flush_count", 32'(flush_count), 32'h0);
      chk("rst_wdt", 32'(wdt_fired), 32'h0);
    end
    cyc(0, 0, 1, 0, 0, 0);
    chk("release_ex_stall", 32'(stall), 32'h0f);
    idle(1);
    chk("release_count", stall_cycles, 32'h1);

    // priority
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 1, 0, 0);
      chk("prio_stall", 32'(stall), 32'h1f);
    end
    idle(1);
    chk("prio_stall_cycles", stall_cycles, 32'd3);
    cyc(0, 1, 0, 0, 0, 0);
    chk("id_stall", 32'(stall), 32'h07);

    // exception mapping
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, codes[i], 32'h1234);
      chk("exc_flush", 32'(flush), 32'h1);
      chk("exc_new_pc", new_pc, pcs[i]);
      idle(2);
    end
    chk("exc_flush_count", 32'(flush_count), 32'd3);

    // lockout
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h8, 0);
    chk("lock_c1_flush", 32'(flush), 32'h1);
    chk("lock_c1_stall", 32'(stall), 32'h0);
    cyc(0, 0, 1, 0, 32'h8, 0);
    chk("lock_c2_flush", 32'(flush), 32'h0);
    chk("lock_c2_stall", 32'(stall), 32'h0);
    chk("lock_c2_new_pc", new_pc, 32'h0);
    cyc(0, 0, 1, 0, 32'h8, 0);
    chk("lock_c3_flush", 32'(flush), 32'h1);
    idle(2);

    // exception during stall
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'ha, 0);
    chk("exstall_flush", 32'(flush), 32'h1);
    chk("exstall_stall", 32'(stall), 32'h0);
    chk("exstall_new_pc", new_pc, 32'h40);
    idle(1);
    chk("exstall_stall_cycles", stall_cycles, 32'd4);
    chk("exstall_flush_count", 32'(flush_count), 32'd1);

    // watchdog
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk("wdt_pre_stall", 32'(stall), 32'h1f);
    end
`ifdef PIPE_CTRL_STALL_WDT_EN
    cyc(0, 0, 0, 1, 0, 0);
    chk("wdt_flush", 32'(flush), 32'h1);
    chk("wdt_new_pc", new_pc, 32'h40);
    chk("wdt_stall", 32'(stall), 32'h0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("wdt_fired", 32'(wdt_fired), 32'h1);
    chk("wdt_lock_stall", 32'(stall), 32'h0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("wdt_restall", 32'(stall), 32'h1f);
`else
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk("nowdt_stall", 32'(stall), 32'h1f);
      chk("nowdt_flush", 32'(flush), 32'h0);
    end
`endif

    // pseudo-random traffic, checked by the model
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          ($urandom_range(0, 7) == 0) ? rcodes[$urandom_range(0, 7)] : 32'h0, $urandom);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
